// File: rtl/fb_scanout.sv
// fb_scanout: raster timing generator that scans a 320x240 RGB332 framebuffer
// pixel- and line-doubled onto the raster, compensating the RAM's registered read.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FB_AW    = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [FB_AW-1:0] rdaddress,
  input  logic [7:0]       q,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [23:0]      rgb,
  output logic             vblank,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int STRIDE = H_ACTIVE / 2;
  // flag vector layout: {de, hsync, vsync, vblank, frame_start}
  localparam logic [4:0] F_RST = {1'b0, ~HS_POL, ~VS_POL, 2'b00};
  logic [HW-1:0]    hcnt;
  logic [VW-1:0]    vcnt;
  logic [FB_AW-1:0] line_base;
  logic             h_end, v_end, act;
  logic [4:0]       f0, f1, f2;
  always_comb begin
    h_end = hcnt == HW'(H_TOTAL - 1);
    v_end = vcnt == VW'(V_TOTAL - 1);
    act   = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
    f0    = {act,
             (hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL,
             (vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL,
             vcnt >= VW'(V_ACTIVE),
             hcnt == '0 && vcnt == '0};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_base <= '0;
    end else begin
      hcnt <= h_end ? '0 : hcnt + HW'(1);
      if (h_end) begin
        vcnt      <= v_end ? '0 : vcnt + VW'(1);
        line_base <= v_end ? '0
                   : (vcnt[0] && vcnt < VW'(V_ACTIVE)) ? line_base + FB_AW'(STRIDE) : line_base;
      end
    end
  end
  // stage 2 is the RAM's own address register, so f2 lines up with q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdaddress <= '0;
      f1        <= F_RST;
      f2        <= F_RST;
      {de, hsync, vsync, vblank, frame_start} <= F_RST;
      rgb       <= '0;
    end else begin
      if (act) rdaddress <= line_base + FB_AW'(hcnt >> 1);
      f1 <= f0;
      f2 <= f1;
      {de, hsync, vsync, vblank, frame_start} <= f2;
      rgb <= f2[4] ? {q[7:5], q[7:5], q[7:6], q[4:2], q[4:2], q[4:3], {4{q[1:0]}}} : '0;
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: random-framebuffer scanout checked against a raster-position model;
// a full-size instance covers the first lines, a shrunk one covers whole frames and reset.
module tb_fb_scanout;
  typedef struct packed { int ha, hf, hs, hb, va, vf, vs, vb; logic hp, vp; } cfg_t;
  typedef struct packed { logic de; logic [23:0] rgb; logic hs, vs, vb, fs; } out_t;
  localparam cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t CS = '{16, 4, 6, 4, 8, 2, 2, 3, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s;
  logic [16:0] rd_d, rd_s;
  logic [7:0] q_d, q_s;
  logic hs_d, vs_d, de_d, vb_d, fs_d, hs_s, vs_s, de_s, vb_s, fs_s;
  logic [23:0] rgb_d, rgb_s;
  logic [7:0] mem [0:76799];

  always @(posedge clk) begin
    q_d <= mem[rd_d];
    q_s <= mem[rd_s];
  end

  fb_scanout dut_d (.clk(clk), .rst_n(rst_d), .rdaddress(rd_d), .q(q_d), .hsync(hs_d),
                    .vsync(vs_d), .de(de_d), .rgb(rgb_d), .vblank(vb_d), .frame_start(fs_d));
  fb_scanout #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4), .V_ACTIVE(8), .V_FP(2),
               .V_SYNC(2), .V_BP(3), .HS_POL(1'b1), .VS_POL(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_s), .rdaddress(rd_s), .q(q_s), .hsync(hs_s), .vsync(vs_s),
    .de(de_s), .rgb(rgb_s), .vblank(vb_s), .frame_start(fs_s));

  function automatic int htot(cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
  function automatic int vtot(cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction
  function automatic bit act_at(cfg_t c, int p);
    int h = p % htot(c);
    int v = (p / htot(c)) % vtot(c);
    return h < c.ha && v < c.va;
  endfunction
  function automatic int addr_at(cfg_t c, int p);
    int h = p % htot(c);
    int v = (p / htot(c)) % vtot(c);
    return (v / 2) * (c.ha / 2) + h / 2;
  endfunction
  function automatic logic [23:0] expand(logic [7:0] x);
    int r = int'(x) >> 5;
    int g = (int'(x) >> 2) & 7;
    int b = int'(x) & 3;
    return {8'((r << 5) | (r << 2) | (r >> 1)), 8'((g << 5) | (g << 2) | (g >> 1)), 8'(b * 85)};
  endfunction
  // n = edges since the first edge out of reset; pins show raster position n-2
  function automatic out_t model(cfg_t c, int n);
    out_t o;
    int p, h, v;
    o = '{1'b0, 24'd0, ~c.hp, ~c.vp, 1'b0, 1'b0};
    if (n < 2) return o;
    p = n - 2;
    h = p % htot(c);
    v = (p / htot(c)) % vtot(c);
    o.de  = act_at(c, p);
    o.rgb = o.de ? expand(mem[addr_at(c, p)]) : 24'd0;
    o.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
    o.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    o.vb  = v >= c.va;
    o.fs  = h == 0 && v == 0;
    return o;
  endfunction

  int ek_d = -1, ek_s = -1, xr_d = 0, xr_s = 0;
  always @(posedge clk) begin
    if (!rst_d) begin
      ek_d <= -1;
      xr_d <= 0;
    end else begin
      ek_d <= ek_d + 1;
      if (act_at(CD, ek_d + 1)) xr_d <= addr_at(CD, ek_d + 1);
    end
    if (!rst_s) begin
      ek_s <= -1;
      xr_s <= 0;
    end else begin
      ek_s <= ek_s + 1;
      if (act_at(CS, ek_s + 1)) xr_s <= addr_at(CS, ek_s + 1);
    end
  end

  int nvec = 0, nerr = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string t, cfg_t c, int n, int xr, logic [16:0] rd, logic de, logic [23:0] rgb,
                     logic hs, logic vs, logic vb, logic fs);
    out_t e = model(c, n);
    chk({t, ".rdaddress"}, 32'(rd), 32'(xr));
    chk({t, ".de"}, 32'(de), 32'(e.de));
    chk({t, ".rgb"}, 32'(rgb), 32'(e.rgb));
    chk({t, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({t, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({t, ".vblank"}, 32'(vb), 32'(e.vb));
    chk({t, ".frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  bit go = 1'b0;
  always @(negedge clk) begin
    if (go) begin
      cmp("full", CD, ek_d, xr_d, rd_d, de_d, rgb_d, hs_d, vs_d, vb_d, fs_d);
      cmp("small", CS, ek_s, xr_s, rd_s, de_s, rgb_s, hs_s, vs_s, vb_s, fs_s);
    end
  end

  task automatic wait_ek(input bit s, input int n);
    int lim = 0;
    while ((s ? ek_s : ek_d) < n && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    if ((s ? ek_s : ek_d) != n) chk(s ? "wait.small" : "wait.full", 32'(s ? ek_s : ek_d), 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 76800; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE3;
    rst_d = 1'b0;
    rst_s = 1'b0;
    @(negedge clk);
    go = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst.hsync", 32'(hs_d), 32'd1);
    chk("rst.vsync", 32'(vs_d), 32'd1);
    chk("rst.de", 32'(de_d), 32'd0);
    chk("rst.rgb", 32'(rgb_d), 32'd0);
    chk("rst.rdaddress", 32'(rd_d), 32'd0);
    chk("rst.frame_start", 32'(fs_d), 32'd0);
    rst_d = 1'b1;
    rst_s = 1'b1;
    wait_ek(0, 1);   chk("lat.de_early", 32'(de_d), 32'd0);
    wait_ek(0, 2);   chk("lat.de_first", 32'(de_d), 32'd1);
                     chk("lat.frame_start", 32'(fs_d), 32'd1);
                     chk("colour.E3_px0", 32'(rgb_d), 32'hFF00FF);
    wait_ek(0, 3);   chk("colour.E3_px1", 32'(rgb_d), 32'hFF00FF);
                     chk("frame_start.one_clock", 32'(fs_d), 32'd0);
    wait_ek(1, 21);  chk("small.hsync_before", 32'(hs_s), 32'd0);
    wait_ek(1, 22);  chk("small.hsync_start", 32'(hs_s), 32'd1);
    wait_ek(1, 226); chk("small.last_addr_held", 32'(rd_s), 32'd31);
    wait_ek(1, 301); chk("small.vsync_before", 32'(vs_s), 32'd1);
    wait_ek(1, 302); chk("small.vsync_start", 32'(vs_s), 32'd0);
    wait_ek(1, 451); chk("small.frame2_addr0", 32'(rd_s), 32'd0);
    wait_ek(1, 452); chk("small.frame_period", 32'(fs_s), 32'd1);
    wait_ek(0, 639); chk("full.line0_end_addr", 32'(rd_d), 32'd319);
    wait_ek(0, 641); chk("full.de_last", 32'(de_d), 32'd1);
    wait_ek(0, 642); chk("full.de_off", 32'(de_d), 32'd0);
    wait_ek(0, 657); chk("full.hsync_before", 32'(hs_d), 32'd1);
    wait_ek(0, 658); chk("full.hsync_start", 32'(hs_d), 32'd0);
    wait_ek(0, 753); chk("full.hsync_last", 32'(hs_d), 32'd0);
    wait_ek(0, 754); chk("full.hsync_end", 32'(hs_d), 32'd1);
    wait_ek(0, 800); chk("full.line1_addr", 32'(rd_d), 32'd0);
    wait_ek(1, 900); chk("small.vblank", 32'(vb_s), 32'd1);
    mem[0] = 8'h1C;
    wait_ek(1, 902); chk("colour.1C_px0", 32'(rgb_s), 32'h00FF00);
                     chk("small.frame3_start", 32'(fs_s), 32'd1);
    wait_ek(1, 1060);
    chk("mid.de_before", 32'(de_s), 32'd1);
    rst_s = 1'b0;
    @(negedge clk);
    chk("mid.de", 32'(de_s), 32'd0);
    chk("mid.rgb", 32'(rgb_s), 32'd0);
    chk("mid.rdaddress", 32'(rd_s), 32'd0);
    chk("mid.hsync", 32'(hs_s), 32'd0);
    chk("mid.vsync", 32'(vs_s), 32'd1);
    rst_s = 1'b1;
    wait_ek(1, 1);   chk("mid.de_early", 32'(de_s), 32'd0);
    wait_ek(1, 2);   chk("mid.frame_start", 32'(fs_s), 32'd1);
                     chk("mid.de_first", 32'(de_s), 32'd1);
    wait_ek(1, 452); chk("mid.frame_period", 32'(fs_s), 32'd1);
    wait_ek(0, 1600); chk("full.line2_addr", 32'(rd_d), 32'd320);
    wait_ek(0, 1602); chk("full.line2_addr_next", 32'(rd_d), 32'd321);
    wait_ek(0, 2500);
    go = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
# fb_scanout

Video scanout stage for the HDMI SoC. It generates raster timing, reads 8-bit pixels from the framebuffer RAM through that RAM's read port, and delivers aligned RGB/sync/DE to the HDMI encoder. The framebuffer is 320x240 at 8 bpp, RGB 3-3-2. It is shown line- and pixel-doubled on a 640x480 raster. The block accounts for the RAM's one-cycle registered-address read.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, hsync width clocks
- H_BP, 48, horizontal back porch clocks
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync width lines
- V_BP, 33, vertical back porch lines
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- FB_AW, 17, framebuffer address width

Ports:
- clk  in  1  pixel clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- rdaddress  out  FB_AW  framebuffer read address, registered
- q  in  8  framebuffer read data; valid one clock after rdaddress is sampled
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, high for active pixels
- rgb  out  24  {R,G,B}, 8 bits each; 0 when de=0
- vblank  out  1  high while the output line is outside V_ACTIVE
- frame_start  out  1  one-clock pulse with the first active pixel of each frame

## Operation
- Counters hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1). H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525).
- hcnt increments every clock and wraps to 0 at H_TOTAL-1.
- vcnt increments when hcnt wraps. vcnt wraps to 0 at V_TOTAL-1.
- Active region: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Hsync is active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. Vsync uses the same rule with the V parameters.
- Address generation uses no multiplier:
  - line_base register, FB_AW bits.
  - Address = line_base + (hcnt>>1).
  - At hcnt wrap, line_base += 320 only if vcnt is odd and vcnt < V_ACTIVE.
  - line_base clears to 0 at vcnt wrap.
- Outside the active region, rdaddress holds its last value. The read result is ignored.
- Pixel expansion:
  - R = {q[7:5], q[7:5], q[7:6]}
  - G = {q[4:2], q[4:2], q[4:3]}
  - B = {q[1:0], q[1:0], q[1:0], q[1:0]}
- Pipeline:
  - Stage 0: counters.
  - Stage 1: rdaddress register, plus delayed de/hs/vs/first flags.
  - Stage 2: the RAM captures the address; q is valid.
  - Stage 3: output registers.
  - hsync, vsync, de, vblank and frame_start are delayed by the same 3 stages, so they stay cycle-aligned with rgb.
- Reset (rst_n=0 at a rising edge):
  - hcnt, vcnt and line_base go to 0.
  - All pipeline stages clear: de=0, rgb=0, rdaddress=0, frame_start=0, vblank=0.
  - hsync = ~HS_POL and vsync = ~VS_POL.
  - Reset mid-frame abandons the frame. The raster restarts at pixel 0, line 0 on release.

## Timing
- Latency from counter state to pins is 3 clocks.
- Release rst_n before edge E0 (first edge with rst_n=1). Then:
  - At E0, counters leave (0,0).
  - The first de=1 with pixel (0,0) appears on the outputs after edge E0+2. Its data comes from address 0.
  - frame_start pulses high for exactly that one clock.
- de is high for 640 consecutive clocks per active line and 480 lines per frame.
- Pixel doubling: each framebuffer address is presented for 2 consecutive clocks. Lines 2k and 2k+1 read identical address ranges.
- Address ranges:
  - Last active address is 239*320+319 = 76799.
  - Addresses never exceed 76799 and never wrap within a frame.
- Output hsync is active for 96 consecutive clocks. It begins 656 clocks after the first de of that line.
- The frame period is exactly 800*525 = 420000 clocks between frame_start pulses.
- vblank is low for output lines 0..479 and high for lines 480..524. It changes on the same clock as the line's first pixel-position output.

## Test plan
- Reset: hold rst_n=0 for 5 clocks with HS_POL=VS_POL=0. Required: hsync=1, vsync=1, de=0, rgb=0, rdaddress=0, frame_start=0. First de=1 occurs exactly 3 clocks after release, with frame_start=1 on that clock.
- Colour path: RAM model returns q=0xE3 at address 0. Required: first pixel rgb=0xFF00FF. Second pixel is the same, since pixel doubling reads address 0 twice. With q=0x1C the output is 0x00FF00.
- Address sequence, RAM model with data = addr[7:0]:
  - Line 0 rdaddress runs 0,0,1,1,…,319,319.
  - Line 1 repeats that sequence.
  - Line 2 starts at 320.
  - Line 479 ends at 76799.
  - Output pixels match the delayed addresses.
- Sync geometry:
  - Per line: 640 de clocks, 16 clocks to hsync, 96 hsync clocks, 48 clocks to the next de.
  - Per frame: vsync active for exactly 2 lines, starting on line 490. vblank is high for 45 lines.
- Frame wrap: run 2 full frames. Required: frame_start pulses exactly 420000 clocks apart, and the second frame restarts at address 0.
- Mid-frame reset: assert rst_n=0 during line 100, pixel 300, for one clock. Required: outputs reach reset values on the next edge. On release, the raster restarts at pixel 0, line 0, and frame_start reappears 3 clocks later.
